// File: rtl/program_loader_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// program_loader_if : byte-receiver input and ICache/CPU-control outputs
// Rev 1.0
// ----------------------------------------------------------------------------
interface program_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        cpu_reset;
  logic [7:0]  write_instruction_index;
  logic [15:0] write_instruction;
  logic        load_done;
  logic        load_error;

  modport master (
    input  rx_valid, rx_byte,
    output cpu_reset, write_instruction_index, write_instruction,
           load_done, load_error
  );

  modport slave (
    output rx_valid, rx_byte,
    input  cpu_reset, write_instruction_index, write_instruction,
           load_done, load_error
  );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// program_loader : byte-stream frame loader filling the CPU ICache, holding
// the CPU in reset until the frame checksum verifies.  Rev 1.0
// ----------------------------------------------------------------------------
module program_loader #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  wire               clk,
  input  wire               reset,
  program_loader_if.master  bus
);

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_CHECK = 3'd4,
    S_RUN   = 3'd5
  } state_t;

  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  acc_q, acc_d;
  logic [8:0]  word_q, word_d;
  logic [7:0]  high_q, high_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  index_q, index_d;
  logic [15:0] instr_q, instr_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        cpu_reset_q, cpu_reset_d;

  logic [8:0]  n_words;
  logic [8:0]  word_inc;
  logic        in_frame;

  // A count byte of zero encodes a full 256-word image.
  assign n_words  = (count_q == 8'd0) ? 9'd256 : {1'b0, count_q};
  assign word_inc = word_q + 9'd1;
  assign in_frame = (state_q == S_COUNT) || (state_q == S_HI) ||
                    (state_q == S_LO)    || (state_q == S_CHECK);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    word_d   = word_q;
    high_d   = high_q;
    timer_d  = timer_q;
    index_d  = index_q;
    instr_d  = instr_q;
    done_d   = 1'b0;
    error_d  = error_q;

    if (bus.rx_valid) begin
      timer_d = 32'd0;
      case (state_q)
        S_HOLD, S_RUN: begin
          if (bus.rx_byte == HEADER) begin
            state_d = S_COUNT;
            error_d = 1'b0;
          end
        end
        S_COUNT: begin
          count_d = bus.rx_byte;
          acc_d   = bus.rx_byte;
          word_d  = 9'd0;
          state_d = S_HI;
        end
        S_HI: begin
          high_d  = bus.rx_byte;
          acc_d   = acc_q ^ bus.rx_byte;
          state_d = S_LO;
        end
        S_LO: begin
          instr_d = {high_q, bus.rx_byte};
          index_d = word_q[7:0];
          acc_d   = acc_q ^ bus.rx_byte;
          word_d  = word_inc;
          state_d = (word_inc == n_words) ? S_CHECK : S_HI;
        end
        S_CHECK: begin
          if (bus.rx_byte == acc_q) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = S_HOLD;
            error_d = 1'b1;
          end
        end
        default: state_d = S_HOLD;
      endcase
    end else if (in_frame) begin
      // Idle gap inside a frame: abort once the gap reaches the limit.
      if (timer_q >= TIMER_LAST) begin
        state_d = S_HOLD;
        error_d = 1'b1;
        high_d  = 8'd0;
        timer_d = 32'd0;
      end else begin
        timer_d = timer_q + 32'd1;
      end
    end else begin
      timer_d = 32'd0;
    end

    cpu_reset_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HOLD;
      count_q     <= 8'd0;
      acc_q       <= 8'd0;
      word_q      <= 9'd0;
      high_q      <= 8'd0;
      timer_q     <= 32'd0;
      index_q     <= 8'd0;
      instr_q     <= 16'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      word_q      <= word_d;
      high_q      <= high_d;
      timer_q     <= timer_d;
      index_q     <= index_d;
      instr_q     <= instr_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  assign bus.cpu_reset               = cpu_reset_q;
  assign bus.write_instruction_index = index_q;
  assign bus.write_instruction       = instr_q;
  assign bus.load_done               = done_q;
  assign bus.load_error              = error_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_program_loader : directed frames with hand-computed expected outputs.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_program_loader;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  program_loader_if bus ();

  program_loader #(
    .HEADER         (8'hA5),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe one byte; called back-to-back this gives consecutive-cycle strobes.
  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'd1);
    check_val({tag, "_index"}, 32'(bus.write_instruction_index), 32'd0);
    check_val({tag, "_instr"}, 32'(bus.write_instruction), 32'd0);
    check_val({tag, "_done"}, 32'(bus.load_done), 32'd0);
    check_val({tag, "_error"}, 32'(bus.load_error), 32'd0);
  endtask

  // Two-word frame, verifying each word and the checksum outcome.
  task automatic frame2(input string tag, input logic [7:0] k, input logic good);
    send(8'hA5);
    check_val({tag, "_err_clr"}, 32'(bus.load_error), 32'd0);
    send(8'h02);
    send(8'h12);
    send(8'h34);
    check_val({tag, "_w0"}, {16'(bus.write_instruction_index), bus.write_instruction},
              32'h0000_1234);
    check_val({tag, "_cpu_held"}, 32'(bus.cpu_reset), 32'd1);
    send(8'h56);
    send(8'h78);
    check_val({tag, "_w1"}, {16'(bus.write_instruction_index), bus.write_instruction},
              32'h0001_5678);
    send(k);
    check_val({tag, "_done"}, 32'(bus.load_done), good ? 32'd1 : 32'd0);
    check_val({tag, "_cpu_reset"}, 32'(bus.cpu_reset), good ? 32'd0 : 32'd1);
    check_val({tag, "_error"}, 32'(bus.load_error), good ? 32'd0 : 32'd1);
    idle(1);
    check_val({tag, "_done_low"}, 32'(bus.load_done), 32'd0);
  endtask

  task automatic frame_abcd(input string tag);
    send(8'hA5);
    send(8'h01);
    send(8'hAB);
    send(8'hCD);
    check_val({tag, "_w0"}, {16'(bus.write_instruction_index), bus.write_instruction},
              32'h0000_ABCD);
    send(8'h67);
    check_val({tag, "_done"}, 32'(bus.load_done), 32'd1);
    check_val({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'd0);
    check_val({tag, "_error"}, 32'(bus.load_error), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    idle(3);
    reset = 1'b0;
    check_reset_values("rst");

    frame2("good", 8'h0A, 1'b1);

    // Non-header byte in RUN is ignored; header reasserts cpu_reset.
    send(8'h5A);
    check_val("run_5a_cpu", 32'(bus.cpu_reset), 32'd0);
    check_val("run_5a_w", {16'(bus.write_instruction_index), bus.write_instruction},
              32'h0001_5678);
    frame2("badk", 8'h0B, 1'b0);

    // Non-header byte in HOLD is ignored.
    send(8'h5A);
    check_val("hold_5a_err", 32'(bus.load_error), 32'd1);
    check_val("hold_5a_cpu", 32'(bus.cpu_reset), 32'd1);
    frame2("recover", 8'h0A, 1'b1);

    // Reload header from RUN holds the CPU from the next cycle.
    send(8'hA5);
    check_val("reload_cpu", 32'(bus.cpu_reset), 32'd1);
    send(8'h01);
    send(8'h12);
    idle(20);
    check_val("tmo_error", 32'(bus.load_error), 32'd1);
    check_val("tmo_cpu", 32'(bus.cpu_reset), 32'd1);
    check_val("tmo_w", {16'(bus.write_instruction_index), bus.write_instruction},
              32'h0001_5678);
    send(8'h34);
    check_val("tmo_hold", {16'(bus.write_instruction_index), bus.write_instruction},
              32'h0001_5678);
    frame_abcd("after_tmo");

    // Full 256-word image with continuous strobes; bytes XOR to zero.
    send(8'hA5);
    send(8'h00);
    for (int w = 0; w < 256; w++) begin
      send(8'(2 * w));
      send(8'(2 * w + 1));
      check_val($sformatf("full_w%0d", w),
                {16'(bus.write_instruction_index), bus.write_instruction},
                {16'(w), 8'(2 * w), 8'(2 * w + 1)});
    end
    check_val("full_cpu_held", 32'(bus.cpu_reset), 32'd1);
    send(8'h00);
    check_val("full_done", 32'(bus.load_done), 32'd1);
    check_val("full_cpu", 32'(bus.cpu_reset), 32'd0);
    check_val("full_last", {16'(bus.write_instruction_index), bus.write_instruction},
              32'h00FF_FEFF);

    // Reset mid-payload, with a header strobe in the reset cycle.
    send(8'hA5);
    send(8'h02);
    send(8'h12);
    send(8'h34);
    send(8'h56);
    reset        = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'hA5;
    @(negedge clk);
    reset        = 1'b0;
    bus.rx_valid = 1'b0;
    check_reset_values("midrst");
    send(8'h02);
    check_val("midrst_ign", {16'(bus.write_instruction_index), bus.write_instruction},
              32'h0000_0000);
    frame_abcd("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
